// File: rtl/fifo_flex_count_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_flex_count_pkg                                |
// | Description : Shared constants and sizing helpers for the        |
// |               fifo_flex_count FIFO.                              |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package fifo_flex_count_pkg;

  // Read-mode encodings for the FWFT parameter
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Default geometry
  localparam int FIFO_DEPTH_WIDTH = 3;
  localparam int DEPTH            = 2 ** FIFO_DEPTH_WIDTH;
  localparam int FIFO_PTR_WIDTH   = FIFO_DEPTH_WIDTH + 1;

  // Number of words for a given address width
  function automatic int fifo_depth(input int depth_width);
    return 1 << depth_width;
  endfunction

  // Pointer width: one extra MSB separates full from empty on wrap
  function automatic int fifo_ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_flex_count_dp_bram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_flex_count_dp_bram                            |
// | Description : Simple dual-port RAM, one write port, one read     |
// |               port with a 1-cycle registered read. The read      |
// |               register clears on reset and holds when not read.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fifo_flex_count_dp_bram
  import fifo_flex_count_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int c_words = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:c_words-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port: array content is not reset
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read port, holds its value when not enabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fifo_flex_count.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_flex_count                                    |
// | Description : Single-clock FIFO with occupancy count, standard   |
// |               or first-word-fall-through read, almost-full/empty |
// |               thresholds, synchronous flush and sticky error     |
// |               flags. Optional macro FIFO_HWM_EN adds the         |
// |               high_water output (maximum count since reset or    |
// |               flush).                                            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fifo_flex_count
  import fifo_flex_count_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = FIFO_DEPTH_WIDTH,
  parameter int FWFT        = FIFO_MODE_STD,
  parameter int AF_THRESH   = 6,
  parameter int AE_THRESH   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  count,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_HWM_EN
  ,
  output logic [DEPTH_WIDTH:0]  high_water
`endif
);

  localparam int c_ptr_w = fifo_ptr_width(DEPTH_WIDTH);
  localparam int c_depth = fifo_depth(DEPTH_WIDTH);

  localparam logic [c_ptr_w-1:0]   c_ptr_one  = {{(c_ptr_w-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0] c_cnt_one  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0] c_cnt_full = c_depth[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] c_af       = AF_THRESH[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] c_ae       = AE_THRESH[DEPTH_WIDTH:0];

  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [DEPTH_WIDTH:0]  r_count;
  logic [DEPTH_WIDTH:0]  w_count_next;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_run;
  logic                  w_wr_accept;
  logic                  w_pop;
  logic                  w_ram_re;
  logic [DATA_WIDTH-1:0] w_ram_q;

  // Reset and flush both suppress any read/write in their cycle
  assign w_run       = rst_n && !flush;
  assign w_wr_accept = w_run && wr_en && !r_full;
  assign w_pop       = w_run && rd_en && !empty;

  fifo_flex_count_dp_bram #(
    .ADDR_WIDTH (DEPTH_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_wr_accept),
    .waddr (r_wr_ptr[DEPTH_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (w_ram_re),
    .raddr (r_rd_ptr[DEPTH_WIDTH-1:0]),
    .rdata (w_ram_q)
  );

  // Next occupancy: a simultaneous write and pop leaves it unchanged
  always_comb begin
    w_count_next = r_count;
    if (w_wr_accept && !w_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (!w_wr_accept && w_pop) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  // RAM write/read pointers; the read pointer follows RAM reads, not pops
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_ram_re) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Registered count, thresholds and sticky error flags
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= (c_af == '0);
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_count        <= w_count_next;
      r_full         <= (w_count_next == c_cnt_full);
      r_almost_full  <= (w_count_next >= c_af);
      r_almost_empty <= (w_count_next <= c_ae);
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Two-stage head: RAM read register, then the output register
    logic                  r_q_valid;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_out_load;
    logic                  w_ram_empty;

    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
    assign w_out_load  = w_run && r_q_valid && (!r_out_valid || w_pop);
    assign w_ram_re    = w_run && !w_ram_empty && (!r_q_valid || w_out_load);

    // Stage valid flags move words from RAM toward the output register
    always_ff @(posedge clk) begin
      if (!w_run) begin
        r_q_valid   <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_ram_re) begin
          r_q_valid <= 1'b1;
        end else if (w_out_load) begin
          r_q_valid <= 1'b0;
        end
        if (w_out_load) begin
          r_out_valid <= 1'b1;
        end else if (w_pop) begin
          r_out_valid <= 1'b0;
        end
      end
    end

    // Output data register: cleared by reset only, held through flush
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_out_data <= '0;
      end else if (w_out_load) begin
        r_out_data <= w_ram_q;
      end
    end

    assign rd_data  = r_out_data;
    assign rd_valid = r_out_valid;
    assign empty    = !r_out_valid;
  end else begin : g_std
    logic r_rd_valid;
    logic r_empty;

    assign w_ram_re = w_pop;

    // One-cycle valid pulse after each accepted read; empty from count
    always_ff @(posedge clk) begin
      if (!w_run) begin
        r_rd_valid <= 1'b0;
        r_empty    <= 1'b1;
      end else begin
        r_rd_valid <= w_pop;
        r_empty    <= (w_count_next == '0);
      end
    end

    assign rd_data  = w_ram_q;
    assign rd_valid = r_rd_valid;
    assign empty    = r_empty;
  end

`ifdef FIFO_HWM_EN
  logic [DEPTH_WIDTH:0] r_high_water;

  // Track the largest occupancy seen since reset or flush
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_high_water <= '0;
    end else if (w_count_next > r_high_water) begin
      r_high_water <= w_count_next;
    end
  end

  assign high_water = r_high_water;
`endif

  assign count        = r_count;
  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire
